window_apply: RTL and testbench

WINDOW_APPLY -- requirements
Module: window_apply

---
 rtl/parzen_pkg.sv | 26 ++
 rtl/window_round_sat.sv | 51 +++++
 rtl/window_apply.sv | 108 ++++++++++
 tb/tb_window_apply.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/parzen_pkg.sv
// Shared fixed-point definitions for the Parzen window generator and the
// window_apply datapath: default widths, typedefs and rounding helpers.
package parzen_pkg;

  localparam int PZ_SAMPLE_W = 16;
  localparam int PZ_WIN_INT  = 10;
  localparam int PZ_WIN_FRAC = 16;
  localparam int PZ_WIN_W    = PZ_WIN_INT + PZ_WIN_FRAC;
  // Signed sample times zero-extended window, sized so the product never overflows.
  localparam int PZ_PROD_W   = PZ_SAMPLE_W + PZ_WIN_W + 1;

  typedef logic        [PZ_WIN_W-1:0]    win_t;
  typedef logic signed [PZ_SAMPLE_W-1:0] sample_t;
  typedef logic signed [PZ_PROD_W-1:0]   prod_t;

  // Window value 1.0 in the generator's fixed-point format.
  localparam win_t PZ_WIN_ONE  = win_t'(1) << PZ_WIN_FRAC;
  // Half-LSB bias added before the fraction is shifted out.
  localparam prod_t PZ_ROUND_HALF = prod_t'(1) <<< (PZ_WIN_FRAC - 1);

  // Product width for arbitrary sample/window geometries.
  function automatic int pz_prod_w(input int sample_w, input int win_int, input int win_frac);
    return sample_w + win_int + win_frac + 1;
  endfunction

endpackage

// File: rtl/window_round_sat.sv
// Round-half-up and output limiting of the full-precision windowed product.
// Build option: define WINDOW_APPLY_SAT_EN to saturate to OUT_W; otherwise the
// rounded value wraps to its low OUT_W bits.
module window_round_sat
  import parzen_pkg::*;
#(
  parameter int PROD_W   = PZ_PROD_W,
  parameter int WIN_FRAC = PZ_WIN_FRAC,
  parameter int OUT_W    = PZ_SAMPLE_W
) (
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [OUT_W-1:0]  data_o
);

  // One guard bit so the half-LSB bias can never carry into the sign.
  localparam int RND_W = PROD_W + 1;
  localparam int SH_W  = RND_W - WIN_FRAC;

  localparam logic signed [RND_W-1:0] HALF =
    {{(RND_W-WIN_FRAC){1'b0}}, 1'b1, {(WIN_FRAC-1){1'b0}}};

  function automatic logic signed [SH_W-1:0] round_half_up(input logic signed [PROD_W-1:0] p);
    logic signed [RND_W-1:0] sum;
    sum = {p[PROD_W-1], p} + HALF;
    // Dropping the fraction bits of a two's-complement value is an arithmetic shift.
    return sum[RND_W-1:WIN_FRAC];
  endfunction

`ifdef WINDOW_APPLY_SAT_EN
  localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SH_W-1:0] MIN_V = {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] limit(input logic signed [SH_W-1:0] r);
    logic signed [SH_W-1:0] c;
    if (r > MAX_V)      c = MAX_V;
    else if (r < MIN_V) c = MIN_V;
    else                c = r;
    return c[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] limit(input logic signed [SH_W-1:0] r);
    return r[OUT_W-1:0];
  endfunction
`endif

  // Purely combinational: the caller registers the result.
  always_comb begin
    data_o = limit(round_half_up(prod_i));
  end

endmodule

// File: rtl/window_apply.sv
// Multiplies each input sample by its paired window value in a 2-stage
// pipeline (product, then round/limit) and tags the last sample of each frame.
// Build option: WINDOW_APPLY_SAT_EN selects saturation instead of wrap.
module window_apply
  import parzen_pkg::*;
#(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int SAMPLE_W         = PZ_SAMPLE_W,
  parameter int WIN_INT          = PZ_WIN_INT,
  parameter int WIN_FRAC         = PZ_WIN_FRAC,
  parameter int OUT_W            = PZ_SAMPLE_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic signed [SAMPLE_W-1:0]    s_data_i,
  input  logic [WIN_INT+WIN_FRAC-1:0]   win_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic signed [OUT_W-1:0]       m_data_o,
  output logic                          m_last_o,
  output logic [WINDOW_SIZE_POW2-1:0]   idx_o
);

  localparam int WIN_W  = WIN_INT + WIN_FRAC;
  localparam int PROD_W = pz_prod_w(SAMPLE_W, WIN_INT, WIN_FRAC);
  localparam logic [WINDOW_SIZE_POW2-1:0] IDX_ONE = {{(WINDOW_SIZE_POW2-1){1'b0}}, 1'b1};

  logic                         adv;
  logic                         in_xfer;
  logic signed [WIN_W:0]        win_ext;
  logic signed [PROD_W-1:0]     prod_full;
  logic signed [OUT_W-1:0]      rounded;

  logic [WINDOW_SIZE_POW2-1:0]  idx_d, idx_q;
  logic                         vld_p1_d, vld_p1_q;
  logic                         last_p1_d, last_p1_q;
  logic signed [PROD_W-1:0]     prod_p1_d, prod_p1_q;
  logic                         vld_p2_d, vld_p2_q;
  logic                         last_p2_d, last_p2_q;
  logic signed [OUT_W-1:0]      data_p2_d, data_p2_q;

  window_round_sat #(
    .PROD_W   (PROD_W),
    .WIN_FRAC (WIN_FRAC),
    .OUT_W    (OUT_W)
  ) u_round_sat (
    .prod_i (prod_p1_q),
    .data_o (rounded)
  );

  // Handshake, index counter and next-state for both pipeline stages.
  always_comb begin
    adv       = m_ready_i || !vld_p2_q;
    s_ready_o = adv && !rst_i;
    in_xfer   = s_valid_i && s_ready_o;
    win_ext   = {1'b0, win_i};
    prod_full = s_data_i * win_ext;

    idx_d     = in_xfer ? idx_q + IDX_ONE : idx_q;

    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    prod_p1_d = prod_p1_q;
    vld_p2_d  = vld_p2_q;
    last_p2_d = last_p2_q;
    data_p2_d = data_p2_q;
    if (adv) begin
      vld_p1_d  = in_xfer;
      last_p1_d = in_xfer && (&idx_q);
      prod_p1_d = prod_full;
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;
      data_p2_d = rounded;
    end
  end

  // Stage 1 -> stage 2 control, index and output register (cleared on reset).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      data_p2_q <= '0;
    end else begin
      idx_q     <= idx_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  // Stage 1 full-precision product; qualified by vld_p1_q so needs no reset.
  always_ff @(posedge clk_i) begin
    prod_p1_q <= prod_p1_d;
  end

  assign m_valid_o = vld_p2_q;
  assign m_data_o  = data_p2_q;
  assign m_last_o  = last_p2_q;
  assign idx_o     = idx_q;

endmodule

// File: tb/tb_window_apply.sv
// Directed bench for window_apply: reset, rounding, limiting, framing,
// backpressure and mid-frame reset.
module tb_window_apply;
  import parzen_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                s_valid_i;
  logic                s_ready_o;
  sample_t             s_data_i;
  win_t                win_i;
  logic                m_valid_o;
  logic                m_ready_i;
  logic signed [15:0]  m_data_o;
  logic                m_last_o;
  logic [9:0]          idx_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  window_apply dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .win_i     (win_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .idx_o     (idx_o)
  );

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; s_valid_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Push one pair through an idle pipeline; report valid one and two cycles later.
  task automatic run_single(input sample_t d, input win_t w,
                            output logic v_early, output logic v,
                            output logic signed [15:0] res, output logic last);
    @(negedge clk_i);
    s_valid_i = 1'b1; s_data_i = d; win_i = w; m_ready_i = 1'b1;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    #1 v_early = m_valid_o;
    @(negedge clk_i);
    #1 v = m_valid_o; res = m_data_o; last = m_last_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 1'b0; m_ready_i = 1'b1; s_data_i = '0; win_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    n_checks++; if (s_ready_o !== 1'b0) $display("FAIL reset_s_ready got=%b exp=0", s_ready_o); else n_pass++;
    n_checks++; if (idx_o !== 10'd0) $display("FAIL reset_idx got=%0d exp=0", idx_o); else n_pass++;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid_o); else n_pass++;
    n_checks++; if (m_data_o !== 16'sd0) $display("FAIL reset_m_data got=%0d exp=0", m_data_o); else n_pass++;
    n_checks++; if (m_last_o !== 1'b0) $display("FAIL reset_m_last got=%b exp=0", m_last_o); else n_pass++;
    rst_i = 1'b0;
    #1;
    n_checks++; if (s_ready_o !== 1'b1) $display("FAIL post_reset_s_ready got=%b exp=1", s_ready_o); else n_pass++;
  endtask

  task automatic test_basic();
    logic ve, v, l; logic signed [15:0] r;
    run_single(16'sd1000, 26'h8000, ve, v, r, l);
    n_checks++; if (ve !== 1'b0) $display("FAIL basic_latency_early got=%b exp=0", ve); else n_pass++;
    n_checks++; if (v !== 1'b1) $display("FAIL basic_valid got=%b exp=1", v); else n_pass++;
    n_checks++; if (r !== 16'sd500) $display("FAIL basic_data got=%0d exp=500", r); else n_pass++;
    n_checks++; if (idx_o !== 10'd1) $display("FAIL basic_idx got=%0d exp=1", idx_o); else n_pass++;
  endtask

  task automatic test_round_neg();
    logic ve, v, l; logic signed [15:0] r;
    run_single(-16'sd3, 26'h8000, ve, v, r, l);
    n_checks++; if (r !== -16'sd1) $display("FAIL round_neg_data got=%0d exp=-1", r); else n_pass++;
    n_checks++; if (l !== 1'b0) $display("FAIL round_neg_last got=%b exp=0", l); else n_pass++;
    run_single(16'sd5, 26'h4000, ve, v, r, l);   // 1.25 rounds to 1
    n_checks++; if (r !== 16'sd1) $display("FAIL round_quarter_data got=%0d exp=1", r); else n_pass++;
    run_single(16'sd3, 26'h8000, ve, v, r, l);   // 1.5 rounds up to 2
    n_checks++; if (r !== 16'sd2) $display("FAIL round_pos_half got=%0d exp=2", r); else n_pass++;
  endtask

  task automatic test_limit();
    logic ve, v, l; logic signed [15:0] r;
    logic signed [15:0] exp_hi, exp_lo;
`ifdef WINDOW_APPLY_SAT_EN
    exp_hi = 16'sd32767;  exp_lo = -16'sd32768;
`else
    exp_hi = -16'sd2;     exp_lo = 16'sd0;
`endif
    run_single(16'sd32767, 26'h20000, ve, v, r, l);
    n_checks++; if (r !== exp_hi) $display("FAIL limit_pos got=%0d exp=%0d", r, exp_hi); else n_pass++;
    run_single(-16'sd32768, 26'h20000, ve, v, r, l);
    n_checks++; if (r !== exp_lo) $display("FAIL limit_neg got=%0d exp=%0d", r, exp_lo); else n_pass++;
    run_single(-16'sd32768, PZ_WIN_ONE, ve, v, r, l);
    n_checks++; if (r !== -16'sd32768) $display("FAIL limit_unity_min got=%0d exp=-32768", r); else n_pass++;
  endtask

  task automatic test_frame();
    int nout = 0, nlast = 0, lastpos = 0, bad = 0, stall_bad = 0;
    sample_t e;
    do_reset();
    for (int i = 0; i < 1028; i++) begin
      @(negedge clk_i);
      m_ready_i = 1'b1;
      if (i < 1024) begin
        s_valid_i = 1'b1; s_data_i = sample_t'((i % 200) - 100); win_i = PZ_WIN_ONE;
      end else begin
        s_valid_i = 1'b0;
      end
      #1;
      if (i < 1024 && s_ready_o !== 1'b1) stall_bad++;
      if (m_valid_o === 1'b1) begin
        nout++;
        e = sample_t'(((nout - 1) % 200) - 100);
        if (m_data_o !== e) bad++;
        if (m_last_o === 1'b1) begin nlast++; lastpos = nout; end
      end
    end
    n_checks++; if (nout != 1024) $display("FAIL frame_count got=%0d exp=1024", nout); else n_pass++;
    n_checks++; if (nlast != 1) $display("FAIL frame_last_count got=%0d exp=1", nlast); else n_pass++;
    n_checks++; if (lastpos != 1024) $display("FAIL frame_last_pos got=%0d exp=1024", lastpos); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL frame_data_errors got=%0d exp=0", bad); else n_pass++;
    n_checks++; if (stall_bad != 0) $display("FAIL frame_ready_drops got=%0d exp=0", stall_bad); else n_pass++;
    n_checks++; if (idx_o !== 10'd0) $display("FAIL frame_idx_wrap got=%0d exp=0", idx_o); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    sample_t q[$];
    sample_t e;
    int sent = 0, nout = 0;
    logic signed [15:0] held_data;
    logic held_last;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk_i);
      s_valid_i = (sent < 12);
      s_data_i  = sample_t'((sent + 1) * 10);
      win_i     = PZ_WIN_ONE;
      m_ready_i = !(cyc >= 4 && cyc < 9);
      #1;
      if (cyc >= 4 && cyc < 9) begin
        n_checks++; if (s_ready_o !== 1'b0) $display("FAIL stall_s_ready cyc=%0d got=%b exp=0", cyc, s_ready_o); else n_pass++;
        n_checks++; if (m_valid_o !== 1'b1) $display("FAIL stall_m_valid cyc=%0d got=%b exp=1", cyc, m_valid_o); else n_pass++;
        if (cyc == 4) begin
          held_data = m_data_o; held_last = m_last_o;
        end else begin
          n_checks++;
          if (m_data_o !== held_data || m_last_o !== held_last)
            $display("FAIL stall_hold cyc=%0d got=%0d/%b exp=%0d/%b", cyc, m_data_o, m_last_o, held_data, held_last);
          else n_pass++;
        end
      end
      if (s_valid_i && s_ready_o) begin
        q.push_back(s_data_i); sent++;
      end
      if (m_valid_o && m_ready_i) begin
        nout++;
        n_checks++;
        if (q.size() == 0) $display("FAIL stall_extra_output got=%0d exp=none", m_data_o);
        else begin
          e = q.pop_front();
          if (m_data_o !== e) $display("FAIL stall_data n=%0d got=%0d exp=%0d", nout, m_data_o, e);
          else n_pass++;
        end
      end
    end
    n_checks++; if (nout != 12) $display("FAIL stall_out_count got=%0d exp=12", nout); else n_pass++;
    n_checks++; if (q.size() != 0) $display("FAIL stall_left_over got=%0d exp=0", q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      s_valid_i = 1'b1; s_data_i = sample_t'(i); win_i = PZ_WIN_ONE; m_ready_i = 1'b1;
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    #1;
    n_checks++; if (idx_o !== 10'd300) $display("FAIL midrst_idx_before got=%0d exp=300", idx_o); else n_pass++;
    s_valid_i = 1'b1; s_data_i = 16'sd300;
    @(negedge clk_i);
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 16'sd55;
    #1;
    n_checks++; if (s_ready_o !== 1'b0) $display("FAIL midrst_s_ready got=%b exp=0", s_ready_o); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0; s_valid_i = 1'b0;
    #1;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL midrst_m_valid got=%b exp=0", m_valid_o); else n_pass++;
    n_checks++; if (idx_o !== 10'd0) $display("FAIL midrst_idx got=%0d exp=0", idx_o); else n_pass++;
    @(negedge clk_i);
    #1;
    n_checks++; if (m_valid_o !== 1'b0) $display("FAIL midrst_stale_valid got=%b exp=0", m_valid_o); else n_pass++;
    s_valid_i = 1'b1; s_data_i = 16'sd7; win_i = PZ_WIN_ONE;
    #1;
    n_checks++; if (idx_o !== 10'd0) $display("FAIL midrst_tag got=%0d exp=0", idx_o); else n_pass++;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    #1;
    n_checks++; if (idx_o !== 10'd1) $display("FAIL midrst_idx_after got=%0d exp=1", idx_o); else n_pass++;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 16'sd7 || m_last_o !== 1'b0)
      $display("FAIL midrst_first_out got=%b/%0d/%b exp=1/7/0", m_valid_o, m_data_o, m_last_o);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_neg();
    test_limit();
    test_frame();
    test_back_to_back_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
